axil_mem_arbiter: RTL

AXIL_MEM_ARBITER -- requirements
Module: axil_mem_arbiter

---
 rtl/axil_mem_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/axil_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axil_mem_arbiter
// Arbitrates two simple valid/ready memory requesters onto one AXI4-Lite
// master port. One AXI transaction is in flight at a time.
//
// Ports
//   clk, resetn          : clock (rising edge), async active-low reset
//   req_valid/req_ready  : per-requester request / one-cycle completion pulse
//   req_instr            : per-requester instruction-fetch flag (sets arprot[2])
//   req_addr/req_wdata   : per-requester 32-bit fields packed at [32*i +: 32]
//   req_wstrb            : per-requester strobes at [4*i +: 4]; zero = read
//   req_rdata            : shared read data, valid while req_ready is high
//   mem_axi_*            : AXI4-Lite master (aw, w, b, ar, r channels)
//
// Parameter
//   PRIO_FIXED           : 0 = round-robin, 1 = requester 0 always wins
// ---------------------------------------------------------------------------
module axil_mem_arbiter #(
    parameter int PRIO_FIXED = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_instr,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic [31:0] req_rdata,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        grant_reg;
    logic        prio_reg;      // requester preferred on the next contested grant
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        instr_reg;
    logic        awvalid_reg;
    logic        wvalid_reg;
    logic        arvalid_reg;
    logic [31:0] rdata_reg;

    // Per-requester views of the packed request buses.
    logic [31:0] addr_arr  [2];
    logic [31:0] wdata_arr [2];
    logic [3:0]  wstrb_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[32*gi +: 32];
            assign wdata_arr[gi] = req_wdata[32*gi +: 32];
            assign wstrb_arr[gi] = req_wstrb[4*gi +: 4];
            // Only DONE raises a ready, and only for the single granted index.
            assign req_ready[gi] = (state_reg == DONE) && (grant_reg == 1'(gi));
        end
    endgenerate

    logic any_req;
    logic win;
    logic win_is_write;
    logic aw_hs, w_hs, ar_hs, r_hs, b_hs;

    // The round-robin pointer only moves on contested grants, so the loser
    // of a contention is the winner of the next one, regardless of how many
    // uncontested grants happen in between.
    always_comb begin
        any_req = |req_valid;
        if (PRIO_FIXED != 0)
            win = ~req_valid[0];
        else if (&req_valid)
            win = prio_reg;
        else
            win = req_valid[1];
        win_is_write = (wstrb_arr[win] != 4'd0);
    end

    assign aw_hs = awvalid_reg & mem_axi_awready;
    assign w_hs  = wvalid_reg & mem_axi_wready;
    assign ar_hs = arvalid_reg & mem_axi_arready;
    assign r_hs  = (state_reg == RD) & mem_axi_rvalid;
    assign b_hs  = (state_reg == WR) & mem_axi_bvalid;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (any_req) state_next = win_is_write ? WR : RD;
            RD:   if (r_hs) state_next = DONE;
            // A response is accepted even if aw/w handshakes are still open.
            WR:   if (b_hs) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_reg   <= 1'b0;
            prio_reg    <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            instr_reg   <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            arvalid_reg <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_reg <= win;
                        addr_reg  <= addr_arr[win];
                        wdata_reg <= wdata_arr[win];
                        wstrb_reg <= wstrb_arr[win];
                        instr_reg <= req_instr[win];
                        if (win_is_write) begin
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                        end else begin
                            arvalid_reg <= 1'b1;
                        end
                        if ((PRIO_FIXED == 0) && (&req_valid))
                            prio_reg <= ~win;
                    end
                end
                RD: begin
                    if (ar_hs)
                        arvalid_reg <= 1'b0;
                    if (r_hs) begin
                        rdata_reg   <= mem_axi_rdata;
                        arvalid_reg <= 1'b0;
                    end
                end
                WR: begin
                    if (aw_hs)
                        awvalid_reg <= 1'b0;
                    if (w_hs)
                        wvalid_reg <= 1'b0;
                    if (b_hs) begin
                        awvalid_reg <= 1'b0;
                        wvalid_reg  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_axi_awvalid = awvalid_reg;
    assign mem_axi_awaddr  = addr_reg;
    assign mem_axi_awprot  = 3'b000;
    assign mem_axi_wvalid  = wvalid_reg;
    assign mem_axi_wdata   = wdata_reg;
    assign mem_axi_wstrb   = wstrb_reg;
    assign mem_axi_bready  = (state_reg == WR);
    assign mem_axi_arvalid = arvalid_reg;
    assign mem_axi_araddr  = addr_reg;
    assign mem_axi_arprot  = {instr_reg, 2'b00};
    assign mem_axi_rready  = (state_reg == RD);
    assign req_rdata       = rdata_reg;

endmodule
